// File: rtl/dispatch_queue.sv
// In-order dispatch queue: buffers decoded instructions, resolves operand tags and routes them to the RS or the LSB.
// Optional DISPATCH_BYPASS_EN: when the queue is empty, an incoming instruction dispatches in its acceptance cycle.
`ifndef OPNUM_W
`define OPNUM_W 6
`endif

module dispatch_queue #(
  parameter int DEPTH = 4,
  parameter int CDB_N = 2,
  parameter int ROB_W = 4,
  parameter int PKT_W = `OPNUM_W+2*32+32+3*5+2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   in_valid,
  input  logic [PKT_W-1:0]       in_pkt,
  output logic                   in_ready,
  output logic [4:0]             rs1_to_reg,
  output logic [4:0]             rs2_to_reg,
  input  logic [ROB_W-1:0]       q1_from_reg,
  input  logic [ROB_W-1:0]       q2_from_reg,
  input  logic [31:0]            v1_from_reg,
  input  logic [31:0]            v2_from_reg,
  input  logic                   q1_ready_from_rob,
  input  logic                   q2_ready_from_rob,
  input  logic [31:0]            v1_from_rob,
  input  logic [31:0]            v2_from_rob,
  input  logic [ROB_W-1:0]       rob_id_from_rob,
  input  logic                   rob_full,
  input  logic                   rs_full,
  input  logic                   ls_full,
  input  logic [CDB_N-1:0]       cdb_valid,
  input  logic [CDB_N*ROB_W-1:0] cdb_rob_id,
  input  logic [CDB_N*32-1:0]    cdb_data,
  input  logic                   rollback,
  output logic                   disp_valid,
  output logic                   disp_to_rs,
  output logic                   disp_to_ls,
  output logic [PKT_W-1:0]       disp_pkt,
  output logic [ROB_W-1:0]       disp_q1,
  output logic [ROB_W-1:0]       disp_q2,
  output logic [31:0]            disp_v1,
  output logic [31:0]            disp_v2,
  output logic [ROB_W-1:0]       disp_rob_id
);

  localparam int AW      = $clog2(DEPTH);
  localparam int RS1_LSB = `OPNUM_W + 5;
  localparam int RS2_LSB = `OPNUM_W + 10;
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    head, tail;
  logic [AW:0]      count;

  logic [PKT_W-1:0] cur_pkt;
  logic             have_entry, bypass_take, enq, do_disp, cur_is_ls, path_free;
  logic             store, pop;
  logic [ROB_W+31:0] op1, op2;

  // Operand priority: x0, then lowest CDB channel hit, then ROB-ready result, then register file.
  function automatic logic [ROB_W+31:0] resolve(
    input logic [4:0]             rs,
    input logic [ROB_W-1:0]       q,
    input logic [31:0]            v_reg,
    input logic                   rob_rdy,
    input logic [31:0]            v_rob,
    input logic [CDB_N-1:0]       cv,
    input logic [CDB_N*ROB_W-1:0] cid,
    input logic [CDB_N*32-1:0]    cd
  );
    logic        hit;
    logic [31:0] hv;
    hit = 1'b0;
    hv  = '0;
    for (int i = CDB_N - 1; i >= 0; i--) begin
      if (cv[i] && (cid[i*ROB_W +: ROB_W] == q)) begin
        hit = 1'b1;
        hv  = cd[i*32 +: 32];
      end
    end
    if (rs == 5'd0)                resolve = '0;
    else if ((q != '0) && hit)     resolve = {{ROB_W{1'b0}}, hv};
    else if ((q != '0) && rob_rdy) resolve = {{ROB_W{1'b0}}, v_rob};
    else                           resolve = {q, v_reg};
  endfunction

  always_comb begin
    in_ready  = !rst && (count < FULL_CNT) && !rollback;
    enq       = in_valid && in_ready && rdy;
`ifdef DISPATCH_BYPASS_EN
    cur_pkt    = (count == '0) ? in_pkt : mem[head];
    have_entry = (count != '0) || enq;
`else
    cur_pkt    = mem[head];
    have_entry = (count != '0);
`endif
    cur_is_ls  = cur_pkt[PKT_W-1];
    path_free  = !rob_full && !(cur_is_ls ? ls_full : rs_full);
    do_disp    = rdy && !rollback && have_entry && path_free;
`ifdef DISPATCH_BYPASS_EN
    bypass_take = do_disp && enq && (count == '0);
`else
    bypass_take = 1'b0;
`endif
    store      = enq && !bypass_take;
    pop        = do_disp && !bypass_take;
    rs1_to_reg = cur_pkt[RS1_LSB +: 5];
    rs2_to_reg = cur_pkt[RS2_LSB +: 5];
    op1 = resolve(rs1_to_reg, q1_from_reg, v1_from_reg, q1_ready_from_rob, v1_from_rob,
                  cdb_valid, cdb_rob_id, cdb_data);
    op2 = resolve(rs2_to_reg, q2_from_reg, v2_from_reg, q2_ready_from_rob, v2_from_rob,
                  cdb_valid, cdb_rob_id, cdb_data);
  end

  // Payload storage carries no reset; only entries below count are ever read as valid.
  always_ff @(posedge clk) begin
    if (store) mem[tail] <= in_pkt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      disp_valid  <= 1'b0;
      disp_to_rs  <= 1'b0;
      disp_to_ls  <= 1'b0;
      disp_pkt    <= '0;
      disp_q1     <= '0;
      disp_q2     <= '0;
      disp_v1     <= '0;
      disp_v2     <= '0;
      disp_rob_id <= '0;
    end else if (rdy) begin
      if (rollback) begin
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        disp_valid <= 1'b0;
        disp_to_rs <= 1'b0;
        disp_to_ls <= 1'b0;
      end else begin
        disp_valid <= do_disp;
        disp_to_rs <= do_disp && !cur_is_ls;
        disp_to_ls <= do_disp && cur_is_ls;
        if (do_disp) begin
          disp_pkt    <= cur_pkt;
          disp_q1     <= op1[ROB_W+31:32];
          disp_v1     <= op1[31:0];
          disp_q2     <= op2[ROB_W+31:32];
          disp_v2     <= op2[31:0];
          disp_rob_id <= rob_id_from_rob;
        end
        if (store) tail <= tail + PTR_ONE;
        if (pop)   head <= head + PTR_ONE;
        case ({store, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
